mining_job_ctrl: RTL and testbench
==================================

// Module: mining_job_ctrl
//
// PURPOSE
//  Sequences one SHA-256d mining job between the SPI slave and the hash core.
//  - Captures a 768-bit job (256-bit midstate + 512-bit block_2) when an SPI
//    frame ends.
//  - Walks the 32-bit nonce field, issuing one hash request per nonce and
//    checking each digest against a leading-zero difficulty.
//  - Publishes status/nonce/digest as the 256-bit word the SPI slave shifts out
//    on the next frame.
//
// PARAMETERS
//  MSG_W        768  job width from SPI: [0:255] midstate, [256:767] block_2
//  HASH_W       256  digest / midstate / miso word width
//  NONCE_W      32   nonce width
//  NONCE_OFFSET 384  bit index of nonce MSB inside block_2 ([0:511] numbering)
//
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous, active-high reset
//  chip_enable   in   1    SPI select, active-low (low = frame in progress)
//  rx_bit_count  in   10   bits received in current/last SPI frame
//  mosi_message  in   768  received job, valid when frame ends
//  difficulty    in   9    required leading zero bits of digest, 0..256
//  hash_start    out  1    one-cycle request to hash core
//  hash_midstate out  256  midstate to hash core, held stable while busy
//  hash_block    out  512  block_2 with current nonce inserted
//  hash_done     in   1    one-cycle pulse, hash_digest valid
//  hash_digest   in   256  digest, MSB = bit 0
//  miso_message  out  256  word for SPI slave to shift out
//  busy          out  1    job in progress (LOAD..CHECK)
//  found         out  1    sticky until next job/reset
//  exhausted     out  1    sticky until next job/reset
//
// BEHAVIOUR
//  - Reset: state IDLE; hash_start/busy/found/exhausted = 0.
//    miso_message, hash_midstate, hash_block and nonce all = 0.
//    cs_prev = 1.
//  - Frame end: cs_prev == 0 && chip_enable == 1.
//    - It is a valid job only if rx_bit_count == 768. Other counts are ignored.
//    - A valid job is accepted in any state and aborts work in flight.
//    - A hash_done for the aborted request is discarded.
//  - FSM transitions:
//    - IDLE -> LOAD on valid job.
//    - LOAD (1 cycle): latch midstate. Latch block_2. Nonce = block_2 field.
//      Clear found/exhausted. Set busy.
//    - START (1 cycle): hash_start = 1. Rising frame edge at cycle N gives
//      hash_start at N+2.
//    - WAIT until hash_done. hash_done outside WAIT is ignored.
//    - CHECK (1 cycle): digest[0:difficulty-1] all zero?
//      - Yes -> FOUND.
//      - No, and nonce == 32'hFFFFFFFF -> EXHAUSTED (no wrap).
//      - No otherwise -> nonce += 1, START.
//    - FOUND / EXHAUSTED: busy = 0, flag = 1. Stay until next valid job.
//  - difficulty == 0: first digest always found. difficulty > 256 is treated
//    as 256.
//  - hash_block = latched block_2 with [NONCE_OFFSET +: 32] replaced by the
//    current nonce. It changes only in LOAD/CHECK, never in START/WAIT.
//  - miso_message format:
//    - [0:7] status: 8'h00 idle, 8'h5B busy, 8'hA5 found, 8'hEE exhausted.
//    - [8:39] nonce.
//    - [40:255] digest[0:215] (zero unless found).
//  - miso_message updates only while chip_enable == 1.
//    - A status change during a frame is held pending and applied on the
//      first cycle chip_enable is high.
//    - The word stays stable for the whole frame.
//  - Sync reset mid-job: next cycle is IDLE with all outputs at reset values.
//    A late hash_done is ignored.
//
// TESTING
//  1. Job with nonce 0x00000010, difficulty 8, core returns digest 0x00F3.. on
//     3rd request:
//     - hash_start at N+2.
//     - nonces 0x10, 0x11, 0x12 seen on hash_block.
//     - found = 1.
//     - miso_message[0:39] = A5_00000012.
//  2. Job nonce 0xFFFFFFFE, difficulty 256, non-zero digests:
//     - exactly 2 hash_start pulses.
//     - exhausted = 1.
//     - status 8'hEE, nonce field FFFFFFFF.
//  3. Second valid job arrives while in WAIT:
//     - stale hash_done dropped.
//     - new midstate/nonce loaded.
//     - hash_start at N+2.
//     - flags cleared.
//  4. Frame ends with rx_bit_count = 767:
//     - no state change.
//     - no hash_start.
//     - miso_message unchanged.
//  5. Found occurs while chip_enable low:
//     - miso_message holds old word (8'h5B..) until chip_enable high.
//     - then A5 word.
//  6. rst asserted in WAIT, hash_done pulses next cycle:
//     - IDLE, all outputs 0.
//     - no CHECK, found stays 0.

Source files
------------

// File: rtl/mining_job_ctrl.sv
// Sequences one SHA-256d mining job: captures the job at SPI frame end, walks the nonce and publishes the status word.
// All vectors are MSB-first: bit 0 of a field in the job/digest numbering is the top bit of the vector.
module mining_job_ctrl #(
  parameter int MSG_W        = 768,
  parameter int HASH_W       = 256,
  parameter int NONCE_W      = 32,
  parameter int NONCE_OFFSET = 384
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      chip_enable,
  input  logic [9:0]                rx_bit_count,
  input  logic [MSG_W-1:0]          mosi_message,
  input  logic [8:0]                difficulty,
  output logic                      hash_start,
  output logic [HASH_W-1:0]         hash_midstate,
  output logic [MSG_W-HASH_W-1:0]   hash_block,
  input  logic                      hash_done,
  input  logic [HASH_W-1:0]         hash_digest,
  output logic [HASH_W-1:0]         miso_message,
  output logic                      busy,
  output logic                      found,
  output logic                      exhausted
);

  localparam int         BLOCK_W   = MSG_W - HASH_W;
  localparam int         NONCE_LSB = BLOCK_W - NONCE_OFFSET - NONCE_W;
  localparam int         DIG_KEEP  = HASH_W - 8 - NONCE_W;
  localparam logic [9:0] JOB_BITS  = 10'(MSG_W);

  localparam logic [7:0] ST_IDLE  = 8'h00;
  localparam logic [7:0] ST_BUSY  = 8'h5B;
  localparam logic [7:0] ST_FOUND = 8'hA5;
  localparam logic [7:0] ST_EXH   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CHECK, S_FOUND, S_EXHAUSTED
  } state_e;

  state_e                state_q;
  logic                  cs_prev_q;
  logic                  hash_start_q;
  logic                  busy_q;
  logic                  found_q;
  logic                  exhausted_q;
  logic [HASH_W-1:0]     midstate_q;
  logic [BLOCK_W-1:0]    hash_block_q;
  logic [NONCE_W-1:0]    nonce_q;
  logic [HASH_W-1:0]     digest_q;
  logic [HASH_W-1:0]     miso_q;

  logic                  job_valid;
  logic [NONCE_W-1:0]    nonce_inc;
  logic [HASH_W-1:0]     zero_mask;
  logic                  digest_ok;
  logic [7:0]            status_d;
  logic [HASH_W-1:0]     miso_d;

  assign job_valid = !cs_prev_q && chip_enable && (rx_bit_count == JOB_BITS);
  assign nonce_inc = nonce_q + NONCE_W'(1);

  // Top `difficulty` bits set; shifts of 256 or more clear everything, so >256 saturates.
  assign zero_mask = ~({HASH_W{1'b1}} >> difficulty);
  assign digest_ok = (digest_q & zero_mask) == '0;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    status_d = ST_IDLE;
    if (busy_q)           status_d = ST_BUSY;
    else if (found_q)     status_d = ST_FOUND;
    else if (exhausted_q) status_d = ST_EXH;
  end

  assign miso_d = {status_d, nonce_q,
                   found_q ? digest_q[HASH_W-1 -: DIG_KEEP] : {DIG_KEEP{1'b0}}};

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cs_prev_q    <= 1'b1;
      hash_start_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      midstate_q   <= '0;
      hash_block_q <= '0;
      nonce_q      <= '0;
      digest_q     <= '0;
      miso_q       <= '0;
    end else begin
      cs_prev_q    <= chip_enable;
      hash_start_q <= 1'b0;
      // The outgoing word is frozen while a frame is being shifted out.
      if (chip_enable) miso_q <= miso_d;

      if (job_valid) begin
        state_q     <= S_LOAD;
        busy_q      <= 1'b1;
        found_q     <= 1'b0;
        exhausted_q <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            midstate_q   <= mosi_message[MSG_W-1 -: HASH_W];
            hash_block_q <= mosi_message[BLOCK_W-1:0];
            nonce_q      <= mosi_message[NONCE_LSB +: NONCE_W];
            hash_start_q <= 1'b1;
            state_q      <= S_START;
          end
          S_START: state_q <= S_WAIT;
          S_WAIT: begin
            if (hash_done) begin
              digest_q <= hash_digest;
              state_q  <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (digest_ok) begin
              busy_q  <= 1'b0;
              found_q <= 1'b1;
              state_q <= S_FOUND;
            end else if (nonce_q == {NONCE_W{1'b1}}) begin
              busy_q      <= 1'b0;
              exhausted_q <= 1'b1;
              state_q     <= S_EXHAUSTED;
            end else begin
              nonce_q                           <= nonce_inc;
              hash_block_q[NONCE_LSB +: NONCE_W] <= nonce_inc;
              hash_start_q                      <= 1'b1;
              state_q                           <= S_START;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hash_start    = hash_start_q;
  assign hash_midstate = midstate_q;
  assign hash_block    = hash_block_q;
  assign miso_message  = miso_q;
  assign busy          = busy_q;
  assign found         = found_q;
  assign exhausted     = exhausted_q;

endmodule

// File: tb/tb_mining_job_ctrl.sv
// Bench for mining_job_ctrl: directed scenarios plus randomized jobs against a nonce-walk reference model.
module tb_mining_job_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         chip_enable = 1'b1;
  logic [9:0]   rx_bit_count = '0;
  logic [767:0] mosi_message = '0;
  logic [8:0]   difficulty = '0;
  logic         hash_done = 1'b0;
  logic [255:0] hash_digest = '0;
  logic         hash_start;
  logic [255:0] hash_midstate;
  logic [511:0] hash_block;
  logic [255:0] miso_message;
  logic         busy;
  logic         found;
  logic         exhausted;

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  logic [255:0] dig_list [$];

  mining_job_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .chip_enable   (chip_enable),
    .rx_bit_count  (rx_bit_count),
    .mosi_message  (mosi_message),
    .difficulty    (difficulty),
    .hash_start    (hash_start),
    .hash_midstate (hash_midstate),
    .hash_block    (hash_block),
    .hash_done     (hash_done),
    .hash_digest   (hash_digest),
    .miso_message  (miso_message),
    .busy          (busy),
    .found         (found),
    .exhausted     (exhausted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hash_start) start_cnt <= start_cnt + 1;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Leading zero bits, counted from the digest MSB (digest bit 0).
  function automatic int clz(input logic [255:0] d);
    int n = 0;
    for (int i = 255; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic send_frame(input logic [767:0] msg, input logic [9:0] bits);
    @(negedge clk);
    chip_enable  = 1'b0;
    rx_bit_count = '0;
    repeat (3) @(negedge clk);
    mosi_message = msg;
    rx_bit_count = bits;
    chip_enable  = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (hash_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sends a full-length job; frame end is sampled at edge N, hash_start must be seen after edge N+1.
  task automatic issue_job(input logic [255:0] mid, input logic [511:0] blk, input logic [8:0] diff,
                           input bit stale, output int base);
    difficulty = diff;
    base = start_cnt;
    send_frame({mid, blk}, 10'd768);
    @(negedge clk);
    total_cnt++;
    if (hash_start !== 1'b0) $display("FAIL start_early: got %b want 0", hash_start);
    else pass_cnt++;
    if (stale) begin
      hash_done   = 1'b1;
      hash_digest = '0;
    end
    @(negedge clk);
    hash_done = 1'b0;
    total_cnt++;
    if (hash_start !== 1'b1) $display("FAIL start_n2: got %b want 1", hash_start);
    else pass_cnt++;
    total_cnt++;
    if ({busy, found, exhausted} !== 3'b100)
      $display("FAIL flags_on_start: got busy/found/exh=%b want 100", {busy, found, exhausted});
    else pass_cnt++;
  endtask

  // Reference model: walk nonces from the job's field, answer each request from dig_list,
  // stop on enough leading zeros or at the last nonce.
  task automatic finish_job(input logic [255:0] mid, input logic [511:0] blk, input int diff,
                            input int base, input string tag);
    logic [31:0]  nonce;
    logic [511:0] exp_blk;
    logic [255:0] d;
    logic [255:0] last_d = '0;
    logic [255:0] exp_miso;
    int           eff;
    int           reqs = 0;
    bit           exp_found = 1'b0;
    bit           exp_exh = 1'b0;
    bit           ok;
    nonce = blk[127:96];
    eff   = (diff > 256) ? 256 : diff;
    while (!exp_found && !exp_exh && reqs < 64) begin
      if (reqs > 0) begin
        wait_start(ok);
        if (!ok) begin
          total_cnt++;
          $display("FAIL %s_start_timeout: no hash_start for request %0d", tag, reqs);
          return;
        end
      end
      reqs++;
      exp_blk = blk;
      exp_blk[127:96] = nonce;
      total_cnt++;
      if (hash_block !== exp_blk)
        $display("FAIL %s_block: got nonce %h want %h", tag, hash_block[127:96], nonce);
      else pass_cnt++;
      total_cnt++;
      if (hash_midstate !== mid) $display("FAIL %s_midstate: got %h want %h", tag, hash_midstate, mid);
      else pass_cnt++;
      d = (reqs - 1 < dig_list.size()) ? dig_list[reqs-1] : {256{1'b1}};
      repeat ($urandom_range(1, 3)) @(negedge clk);
      hash_done   = 1'b1;
      hash_digest = d;
      @(negedge clk);
      hash_done   = 1'b0;
      hash_digest = rand256();
      if (clz(d) >= eff) begin
        exp_found = 1'b1;
        last_d    = d;
      end else if (nonce == 32'hFFFF_FFFF) begin
        exp_exh = 1'b1;
      end else begin
        nonce = nonce + 32'd1;
      end
    end
    repeat (3) @(negedge clk);
    exp_miso = {exp_found ? 8'hA5 : 8'hEE, nonce, exp_found ? last_d[255:40] : 216'd0};
    total_cnt++;
    if ({busy, found, exhausted} !== {1'b0, exp_found, exp_exh})
      $display("FAIL %s_flags: got busy/found/exh=%b want %b", tag, {busy, found, exhausted},
               {1'b0, exp_found, exp_exh});
    else pass_cnt++;
    total_cnt++;
    if (start_cnt - base !== reqs)
      $display("FAIL %s_start_count: got %0d want %0d", tag, start_cnt - base, reqs);
    else pass_cnt++;
    total_cnt++;
    if (miso_message !== exp_miso)
      $display("FAIL %s_miso: got %h want %h", tag, miso_message, exp_miso);
    else pass_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    total_cnt++;
    if ({hash_start, busy, found, exhausted} !== 4'b0 || miso_message !== '0 ||
        hash_block !== '0 || hash_midstate !== '0)
      $display("FAIL %s: got start/busy/found/exh=%b miso=%h want all zero", tag,
               {hash_start, busy, found, exhausted}, miso_message);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_found_directed();
    logic [255:0] mid = rand256();
    logic [511:0] blk = {rand256(), rand256()};
    logic [255:0] d0 = rand256();
    logic [255:0] d1 = rand256();
    logic [255:0] d2 = rand256();
    int base;
    blk[127:96] = 32'h0000_0010;
    d0[255:248] = 8'h01;
    d1[255:248] = 8'hFF;
    d2[255:240] = 16'h00F3;
    dig_list = '{d0, d1, d2};
    issue_job(mid, blk, 9'd8, 1'b0, base);
    finish_job(mid, blk, 8, base, "found");
    total_cnt++;
    if (miso_message[255:216] !== 40'hA5_0000_0012)
      $display("FAIL found_word: got %h want a500000012", miso_message[255:216]);
    else pass_cnt++;
  endtask

  task automatic test_exhaust();
    logic [255:0] mid = rand256();
    logic [511:0] blk = {rand256(), rand256()};
    logic [255:0] d0 = rand256();
    logic [255:0] d1 = rand256();
    int base;
    blk[127:96] = 32'hFFFF_FFFE;
    d0[255] = 1'b1;
    d1[0]   = 1'b1;
    dig_list = '{d0, d1};
    issue_job(mid, blk, 9'd256, 1'b0, base);
    finish_job(mid, blk, 256, base, "exhaust");
    total_cnt++;
    if (start_cnt - base !== 2) $display("FAIL exhaust_starts: got %0d want 2", start_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if (miso_message[255:216] !== 40'hEE_FFFF_FFFF || exhausted !== 1'b1)
      $display("FAIL exhaust_word: got %h exh=%b want eeffffffff exh=1", miso_message[255:216], exhausted);
    else pass_cnt++;
  endtask

  task automatic test_bad_length();
    logic [255:0] held_miso = miso_message;
    logic [255:0] held_mid = hash_midstate;
    int base = start_cnt;
    send_frame({rand256(), rand256(), rand256()}, 10'd767);
    repeat (6) @(negedge clk);
    total_cnt++;
    if (start_cnt !== base) $display("FAIL badlen_start: got %0d pulses want 0", start_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if ({busy, exhausted} !== 2'b01 || hash_midstate !== held_mid)
      $display("FAIL badlen_state: got busy/exh=%b want 01", {busy, exhausted});
    else pass_cnt++;
    total_cnt++;
    if (miso_message !== held_miso) $display("FAIL badlen_miso: got %h want %h", miso_message, held_miso);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [255:0] mid_a = rand256();
    logic [511:0] blk_a = {rand256(), rand256()};
    logic [255:0] mid_b = rand256();
    logic [511:0] blk_b = {rand256(), rand256()};
    logic [255:0] d0 = rand256();
    int base;
    d0[255:252] = 4'h0;
    dig_list = '{d0};
    issue_job(mid_a, blk_a, 9'd4, 1'b0, base);
    @(negedge clk);
    issue_job(mid_b, blk_b, 9'd4, 1'b1, base);
    finish_job(mid_b, blk_b, 4, base, "abort");
  endtask

  task automatic test_miso_hold();
    logic [255:0] mid = rand256();
    logic [511:0] blk = {rand256(), rand256()};
    logic [255:0] held;
    int base;
    issue_job(mid, blk, 9'd8, 1'b0, base);
    @(negedge clk);
    chip_enable  = 1'b0;
    rx_bit_count = '0;
    held = miso_message;
    total_cnt++;
    if (held[255:248] !== 8'h5B) $display("FAIL hold_busy_word: got %h want 5b", held[255:248]);
    else pass_cnt++;
    @(negedge clk);
    hash_done   = 1'b1;
    hash_digest = '0;
    @(negedge clk);
    hash_done = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (found !== 1'b1 || miso_message !== held)
      $display("FAIL hold_frozen: got found=%b miso=%h want found=1 miso=%h", found, miso_message, held);
    else pass_cnt++;
    rx_bit_count = 10'd256;
    chip_enable  = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (miso_message !== {8'hA5, blk[127:96], 216'd0})
      $display("FAIL hold_release: got %h want a5%h", miso_message[255:216], blk[127:96]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 24; j++) begin
      logic [255:0] mid = rand256();
      logic [511:0] blk = {rand256(), rand256()};
      logic [255:0] r;
      int diff, eff, target, lz, base;
      diff = (j == 0) ? 0 : (j == 1) ? 300 : (j == 2) ? 256 : $urandom_range(0, 300);
      eff = (diff > 256) ? 256 : diff;
      target = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) blk[127:96] = 32'hFFFF_FFFF - $urandom_range(0, 3);
      dig_list = {};
      for (int i = 0; i < target; i++) begin
        r = rand256();
        if (eff == 0) begin
          dig_list.push_back(r);
        end else begin
          lz = $urandom_range(0, eff - 1);
          dig_list.push_back((r >> lz) | (256'b1 << (255 - lz)));
        end
      end
      dig_list.push_back(rand256() >> eff);
      issue_job(mid, blk, 9'(diff), 1'b0, base);
      finish_job(mid, blk, diff, base, "rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] mid = rand256();
    logic [511:0] blk = {rand256(), rand256()};
    int base;
    issue_job(mid, blk, 9'd8, 1'b0, base);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    hash_done   = 1'b1;
    hash_digest = '0;
    check_all_zero("rstmid_now");
    @(negedge clk);
    hash_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rstmid_late_done");
    total_cnt++;
    if (start_cnt - base !== 1) $display("FAIL rstmid_starts: got %0d want 1", start_cnt - base);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_found_directed();
    test_exhaust();
    test_bad_length();
    test_abort();
    test_miso_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
